// File: rtl/hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state encoding,
// the packed pipeline-control bundle and its canonical values.
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  // Pipeline control bundle, MSB first.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_hold;
  } ctrl_t;

  // Normal advance.
  localparam ctrl_t CTRL_IDLE   = 5'b11000;
  // NOP controls driven while reset is asserted: nothing advances, both
  // front-end registers load NOPs.
  localparam ctrl_t CTRL_NOP    = 5'b00110;
  // Whole-pipe freeze during a data-memory wait (and in ERROR).
  localparam ctrl_t CTRL_FREEZE = 5'b00001;
  // Load-use bubble: hold PC and IF/ID, inject a NOP into ID/EX.
  localparam ctrl_t CTRL_STALL  = 5'b00010;
  // Taken branch: redirect PC, squash the wrong-path fetch in IF/ID.
  localparam ctrl_t CTRL_FLUSH  = 5'b11100;

  // Load-use hazard: EX load writes a register the ID instruction reads.
  function automatic logic load_use_hit(
    input logic       ex_memread,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_use_rs1,
    input logic       id_use_rs2
  );
    return ex_memread && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (ex_rd == id_rs1)) ||
            (id_use_rs2 && (ex_rd == id_rs2)));
  endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count enabled cycles, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush sequencer for the five-stage core. Arbitrates data-memory
// freeze, load-use bubble and ID-resolved branch flush, drives the dmem
// request, detects memory timeout and keeps saturating statistics.
//
// Handshake: dmem_req_o is asserted in every non-ERROR cycle in which the MEM
// stage holds a load/store; the access completes in the cycle where
// dmem_req_o and dmem_ack_i are both high. Without ack the whole pipe holds
// and the request stays up until ack, timeout (ERROR) or reset.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_access_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic             pipe_hold_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output state_t           state_o
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  ctrl_t             ctrl;
  logic              req;
  logic              freeze;
  logic              lu_hit;

  assign freeze = mem_access_i & ~dmem_ack_i;
  assign lu_hit = load_use_hit(ex_memread_i, ex_rd_i, id_rs1_i, id_rs2_i,
                               id_use_rs1_i, id_use_rs2_i);

  // Same-cycle control decode and next-state/wait-count selection.
  always_comb begin
    ctrl       = CTRL_IDLE;
    req        = 1'b0;
    next_state = state;
    wait_next  = '0;
    if (!rst_i) begin
      ctrl       = CTRL_NOP;
      next_state = ST_RUN;
    end else if (state == ST_ERROR) begin
      ctrl       = CTRL_FREEZE;
      next_state = ST_ERROR;
    end else begin
      req = mem_access_i;
      if (freeze) begin
        ctrl = CTRL_FREEZE;
        // The first un-acked cycle (seen in RUN/BUBBLE) counts as wait 1.
        if (state == ST_MEM_WAIT) begin
          if (wait_cnt == WAIT_LAST) begin
            next_state = ST_ERROR;
          end else begin
            next_state = ST_MEM_WAIT;
            wait_next  = wait_cnt + 1'b1;
          end
        end else begin
          next_state = ST_MEM_WAIT;
          wait_next  = WAIT_W'(1);
        end
      end else if (lu_hit && (state != ST_BUBBLE)) begin
        // Branch is ignored: its operands are stale behind the load.
        ctrl       = CTRL_STALL;
        next_state = ST_BUBBLE;
      end else if (id_branch_taken_i) begin
        ctrl       = CTRL_FLUSH;
        next_state = ST_RUN;
      end else begin
        next_state = ST_RUN;
      end
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_next;
      if (next_state == ST_ERROR) begin
        err_o <= 1'b1;
      end
    end
  end

  assign dmem_req_o     = req;
  assign pc_write_o     = ctrl.pc_write;
  assign if_id_write_o  = ctrl.if_id_write;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_bubble_o = ctrl.id_ex_bubble;
  assign pipe_hold_o    = ctrl.pipe_hold;
  assign state_o        = state;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .clr_n (rst_i),
    .en    (~ctrl.pc_write),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .clr_n (rst_i),
    .en    (ctrl.if_id_flush),
    .count (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (CNT_W=4, MAX_WAIT=4): a per-cycle
// vector table for control decode, plus hand sequences for memory wait,
// deferred hazards, timeout and counter saturation.
module tb_hazard_sequencer;
  import hazard_sequencer_pkg::*;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ex_memread, id_use_rs1, id_use_rs2, br_taken;
  logic             mem_access, dmem_ack;
  logic [4:0]       ex_rd, id_rs1, id_rs2;
  logic             dmem_req, pc_write, if_id_write, if_id_flush;
  logic             id_ex_bubble, pipe_hold, err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  state_t           state;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  hazard_sequencer #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ex_memread_i      (ex_memread),
    .ex_rd_i           (ex_rd),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs1_i      (id_use_rs1),
    .id_use_rs2_i      (id_use_rs2),
    .id_branch_taken_i (br_taken),
    .mem_access_i      (mem_access),
    .dmem_ack_i        (dmem_ack),
    .dmem_req_o        (dmem_req),
    .pc_write_o        (pc_write),
    .if_id_write_o     (if_id_write),
    .if_id_flush_o     (if_id_flush),
    .id_ex_bubble_o    (id_ex_bubble),
    .pipe_hold_o       (pipe_hold),
    .err_o             (err),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt),
    .state_o           (state)
  );

  // Inputs: memread, rd, rs1, rs2, use1, use2, branch, mem, ack.
  // Expected outputs: {pc_write, if_id_write, flush, bubble, hold, req}.
  typedef struct {
    string      name;
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       mem;
    logic       ack;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, dmem_req};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic memread, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use1, input logic use2,
                       input logic br, input logic mem, input logic ack);
    ex_memread = memread; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = use1; id_use_rs2 = use2; br_taken = br;
    mem_access = mem; dmem_ack = ack;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Check outputs mid-cycle, then advance to just after the next edge.
  task automatic cycle_check(input string name, input logic [5:0] exp);
    @(negedge clk);
    check(name, 32'(outs()), 32'(exp));
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    cycles(2);
    rst = 1'b1;
  endtask

  task automatic add(input string nm, input logic memread, input logic [4:0] rd,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                     input logic use2, input logic br, input logic mem, input logic ack,
                     input logic [5:0] exp);
    vec_t v;
    v.name = nm; v.memread = memread; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.use1 = use1; v.use2 = use2; v.br = br; v.mem = mem; v.ack = ack; v.exp = exp;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    idle();
    // Applied back to back from RUN; expectations include state carried over.
    add("v_idle",        0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 6'b110000);
    add("v_lu_rs1",      1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 6'b000100);
    add("v_bubble_supp", 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, 6'b110000);
    add("v_rd_zero",     1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 6'b110000);
    add("v_rs2_unused",  1, 5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 0, 6'b110000);
    add("v_lu_rs2",      1, 5'd5, 5'd1, 5'd5, 0, 1, 0, 0, 0, 6'b000100);
    add("v_br_bubble",   0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 6'b111000);
    add("v_br_lu",       1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 0, 0, 6'b000100);
    add("v_br_retry",    1, 5'd7, 5'd7, 5'd0, 1, 0, 1, 0, 0, 6'b111000);
    add("v_mem_ack",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 6'b110001);
    add("v_mem_ack_br",  0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 6'b111001);
    add("v_no_memread",  0, 5'd9, 5'd9, 5'd9, 1, 1, 0, 0, 0, 6'b110000);
    add("v_ack_lu",      1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 1, 1, 6'b000101);
    add("v_after_ack_lu",0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 6'b110000);

    // Reset: controls while rst low, then cleared registers.
    rst = 1'b0;
    #1;
    check("rst_outs", 32'(outs()), 32'(6'b001100));
    cycles(2);
    rst = 1'b1;
    check("rst_state", 32'(state), 32'(ST_RUN));
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_flush_cnt", 32'(flush_cnt), 32'd0);

    // Table-driven decode: stalls = 4 (v_lu_rs1, v_lu_rs2, v_br_lu, v_ack_lu),
    // flushes = 3 (v_br_bubble, v_br_retry, v_mem_ack_br).
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].use1,
            vecs[i].use2, vecs[i].br, vecs[i].mem, vecs[i].ack);
      cycle_check(vecs[i].name, vecs[i].exp);
    end
    check("tbl_stall_cnt", 32'(stall_cnt), 32'd4);
    check("tbl_flush_cnt", 32'(flush_cnt), 32'd3);
    check("tbl_state", 32'(state), 32'(ST_RUN));

    // Single load-use: exactly one stall cycle.
    do_reset();
    drive(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    cycle_check("lu_stall", 6'b000100);
    check("lu_state_bubble", 32'(state), 32'(ST_BUBBLE));
    idle();
    cycle_check("lu_next", 6'b110000);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait of 3 cycles, ack on the fourth; done twice to show the
    // wait counter restarts (6 freeze cycles total stays below timeout).
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        cycle_check($sformatf("mw_freeze_%0d_%0d", r, k), 6'b000011);
      end
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
      cycle_check($sformatf("mw_ack_%0d", r), 6'b110001);
      check($sformatf("mw_state_%0d", r), 32'(state), 32'(ST_RUN));
    end
    check("mw_stall_cnt", 32'(stall_cnt), 32'd6);
    check("mw_err", 32'(err), 32'd0);

    // Freeze concurrent with load-use and branch: both deferred.
    do_reset();
    drive(1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1, 0);
    cycle_check("df_freeze", 6'b000011);
    drive(1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 1, 1);
    cycle_check("df_ack_lu", 6'b000101);
    check("df_state_bubble", 32'(state), 32'(ST_BUBBLE));
    drive(1, 5'd4, 5'd4, 5'd0, 1, 0, 1, 0, 0);
    cycle_check("df_branch", 6'b111000);
    check("df_flush_cnt", 32'(flush_cnt), 32'd1);
    check("df_stall_cnt", 32'(stall_cnt), 32'd2);

    // Timeout after MAX_WAIT un-acked cycles; ERROR held until reset.
    do_reset();
    for (int k = 0; k < MAX_WAIT; k++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
      cycle_check($sformatf("to_wait_%0d", k), 6'b000011);
      if (k < MAX_WAIT - 1) check($sformatf("to_noerr_%0d", k), 32'(err), 32'd0);
    end
    check("to_err", 32'(err), 32'd1);
    check("to_state", 32'(state), 32'(ST_ERROR));
    drive(1, 5'd2, 5'd2, 5'd0, 1, 0, 1, 1, 1);
    cycle_check("to_frozen_ack", 6'b000010);
    cycle_check("to_frozen_2", 6'b000010);
    check("to_err_sticky", 32'(err), 32'd1);
    do_reset();
    check("to_rst_state", 32'(state), 32'(ST_RUN));
    check("to_rst_err", 32'(err), 32'd0);
    cycle_check("to_rst_idle", 6'b110000);

    // Stall counter saturation: 20 stall cycles (wait then ERROR) hold at 15.
    do_reset();
    drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    cycles(14);
    check("sat_14", 32'(stall_cnt), 32'd14);
    cycles(1);
    check("sat_15", 32'(stall_cnt), 32'd15);
    cycles(5);
    check("sat_hold", 32'(stall_cnt), 32'd15);
    do_reset();
    check("sat_cleared", 32'(stall_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
